// File: rtl/prm_pkg.sv
// rtl/prm_pkg.sv - shared constants and FSM state type for the edge-result scanner
package prm_pkg;
   localparam int NUM_BANKS      = 4;
   localparam int WORDS_PER_BANK = 16;
   localparam int WORD_W         = 32;
   localparam int TOTAL_WORDS    = NUM_BANKS * WORDS_PER_BANK;
   localparam int ADDR_W         = 6;
   localparam int BIT_W          = $clog2(WORD_W);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
endpackage

// File: rtl/prm_scan_fifo.sv
// rtl/prm_scan_fifo.sv - synchronous FIFO whose head entry drives the output directly
module prm_scan_fifo #(
   parameter int WIDTH = 39,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // push is gated by the start-of-cycle full flag, so a same-cycle pop never bypasses
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_data    = r_mem[r_rd_ptr];

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/prm_result_scan.sv
// rtl/prm_result_scan.sv - sweeps all result words through the readout mux, streams them
// out and accumulates set-bit count and lowest set-bit index
module prm_result_scan
   import prm_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              start,
   output logic [2:0]        sel1,
   output logic [7:0]        sel2,
   input  logic [WORD_W-1:0] result_imp,
   output logic [WORD_W-1:0] m_data,
   output logic [5:0]        m_index,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done,
   output logic [11:0]       hit_count,
   output logic [10:0]       first_hit,
   output logic              first_hit_valid
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_WORDS - 1);
   localparam logic [11:0]       HIT_MAX   = 12'd2047;
   localparam int                ENTRY_W   = WORD_W + ADDR_W + 1;

   function automatic logic [BIT_W:0] popcount(input logic [WORD_W-1:0] w);
      popcount = '0;
      for (int i = 0; i < WORD_W; i++) popcount = popcount + (BIT_W+1)'(w[i]);
   endfunction

   function automatic logic [BIT_W-1:0] lowest_set(input logic [WORD_W-1:0] w);
      lowest_set = '0;
      for (int i = WORD_W - 1; i >= 0; i--) if (w[i]) lowest_set = BIT_W'(i);
   endfunction

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [11:0]         r_hit_count;
   logic [10:0]         r_first_hit;
   logic                r_first_hit_valid;
   logic                w_push;
   logic                w_full;
   logic                w_empty;
   logic [ENTRY_W-1:0]  w_head;
   logic [12:0]         w_hit_sum;
   logic [11:0]         w_hit_next;

   assign sel1      = {1'b0, r_addr[5:4]};
   assign sel2      = {4'b0, r_addr[3:0]};
   assign busy      = (r_state != IDLE);
   assign w_push    = (r_state == SCAN) && !w_full;
   assign m_valid   = !w_empty;
   assign m_data    = w_head[WORD_W-1:0];
   assign m_index   = w_head[WORD_W +: ADDR_W];
   assign m_last    = w_head[ENTRY_W-1];
   assign hit_count = r_hit_count;
   assign first_hit = r_first_hit;
   assign first_hit_valid = r_first_hit_valid;

   assign w_hit_sum  = {1'b0, r_hit_count} + 13'(popcount(result_imp));
   assign w_hit_next = (w_hit_sum > 13'(HIT_MAX)) ? HIT_MAX : w_hit_sum[11:0];

   prm_scan_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST_n   (RST_n),
      .i_push  (w_push),
      .i_data  ({(r_addr == LAST_ADDR), r_addr, result_imp}),
      .i_pop   (m_ready),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge CLK) begin
      if (!RST_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      done         = 1'b0;
      case (r_state)
         IDLE:  if (start) w_next_state = SCAN;
         SCAN:  if (w_push && r_addr == LAST_ADDR) w_next_state = DRAIN;
         DRAIN: if (w_empty) begin
            done         = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         r_addr            <= '0;
         r_hit_count       <= '0;
         r_first_hit       <= '0;
         r_first_hit_valid <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_addr            <= '0;
         r_hit_count       <= '0;
         r_first_hit       <= '0;
         r_first_hit_valid <= 1'b0;
      end else if (w_push) begin
         // the word sampled here was addressed by r_addr for the whole cycle
         r_addr      <= r_addr + ADDR_W'(1);
         r_hit_count <= w_hit_next;
         if (!r_first_hit_valid && result_imp != '0) begin
            r_first_hit       <= {r_addr, lowest_set(result_imp)};
            r_first_hit_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_prm_result_scan.sv
// tb/tb_prm_result_scan.sv - self-checking bench for prm_result_scan against a word-array model
module tb_prm_result_scan;
   logic        CLK = 1'b0;
   logic        RST_n;
   logic        start;
   logic [2:0]  sel1;
   logic [7:0]  sel2;
   logic [31:0] result_imp;
   logic [31:0] m_data;
   logic [5:0]  m_index;
   logic        m_last;
   logic        m_valid;
   logic        m_ready;
   logic        busy;
   logic        done;
   logic [11:0] hit_count;
   logic [10:0] first_hit;
   logic        first_hit_valid;

   logic [31:0] bank [64];
   int n_assert = 0;
   int n_fail   = 0;

   assign result_imp = bank[{sel1[1:0], sel2[3:0]}];
   always #5 CLK = ~CLK;

   prm_result_scan #(.FIFO_DEPTH(4)) dut (
      .CLK             (CLK),
      .RST_n           (RST_n),
      .start           (start),
      .sel1            (sel1),
      .sel2            (sel2),
      .result_imp      (result_imp),
      .m_data          (m_data),
      .m_index         (m_index),
      .m_last          (m_last),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .busy            (busy),
      .done            (done),
      .hit_count       (hit_count),
      .first_hit       (first_hit),
      .first_hit_valid (first_hit_valid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sel1"}, sel1, 0);
      chk({tag, "_sel2"}, sel2, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_m_index"}, m_index, 0);
      chk({tag, "_m_last"}, m_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_hit_count"}, hit_count, 0);
      chk({tag, "_first_hit"}, first_hit, 0);
      chk({tag, "_first_hit_valid"}, first_hit_valid, 0);
   endtask

   task automatic fill_random();
      for (int k = 0; k < 64; k++) begin
         case ($urandom_range(0, 2))
            0:       bank[k] = 32'h0;
            1:       bank[k] = $urandom;
            default: bank[k] = 32'h1 << $urandom_range(0, 31);
         endcase
      end
   endtask

   // One full sweep; expectations come from the bank array, not from the DUT.
   task automatic sweep(input string name, input int stall, input bit rnd_ready,
                        input int restart_c);
      logic [31:0] got_data [64];
      logic [5:0]  got_idx [64];
      logic        got_last [64];
      logic [38:0] prev;
      bit          hold;
      int          nbeats, done_cnt, done_cycle, exp_hits, exp_first;
      bit          exp_fv;

      exp_hits = 0;
      exp_fv = 0;
      exp_first = 0;
      for (int k = 0; k < 64; k++) begin
         exp_hits += $countones(bank[k]);
         for (int b = 0; b < 32; b++)
            if (!exp_fv && bank[k][b]) begin
               exp_fv = 1;
               exp_first = k * 32 + b;
            end
      end
      if (exp_hits > 2047) exp_hits = 2047;

      nbeats = 0;
      done_cnt = 0;
      done_cycle = -1;
      hold = 0;
      prev = '0;

      @(negedge CLK);
      start = 1'b1;
      m_ready = (stall == 0);
      for (int c = 1; c <= 400; c++) begin
         @(negedge CLK);
         start = (c == restart_c);
         m_ready = (c <= stall) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         if (c == 1) chk({name, "_busy_rise"}, busy, 1);
         if (stall >= 5 && c == stall) begin
            chk({name, "_stall_sel2"}, sel2, 4);
            chk({name, "_stall_sel1"}, sel1, 0);
            chk({name, "_stall_valid"}, m_valid, 1);
            chk({name, "_stall_index"}, m_index, 0);
         end
         if (hold) chk({name, "_stable"}, {m_last, m_index, m_data}, prev);
         hold = m_valid && !m_ready;
         prev = {m_last, m_index, m_data};
         if (m_valid && m_ready) begin
            if (nbeats < 64) begin
               got_data[nbeats] = m_data;
               got_idx[nbeats]  = m_index;
               got_last[nbeats] = m_last;
            end
            nbeats++;
         end
         if (done) begin
            done_cnt++;
            if (done_cycle < 0) done_cycle = c;
         end
         if (done_cycle >= 0 && c == done_cycle + 1) begin
            chk({name, "_busy_fall"}, busy, 0);
            break;
         end
      end
      start = 1'b0;

      chk({name, "_done_count"}, done_cnt, 1);
      chk({name, "_beats"}, nbeats, 64);
      for (int i = 0; i < 64 && i < nbeats; i++) begin
         chk($sformatf("%s_idx%0d", name, i), got_idx[i], i);
         chk($sformatf("%s_data%0d", name, i), got_data[i], bank[i]);
         chk($sformatf("%s_last%0d", name, i), got_last[i], (i == 63));
      end
      chk({name, "_hit_count"}, hit_count, exp_hits);
      chk({name, "_first_hit_valid"}, first_hit_valid, exp_fv);
      chk({name, "_first_hit"}, first_hit, exp_first);
      if (stall == 0 && !rnd_ready) chk({name, "_done_latency"}, done_cycle, 66);
   endtask

   initial begin
      RST_n = 1'b0;
      start = 1'b0;
      m_ready = 1'b0;
      for (int k = 0; k < 64; k++) bank[k] = 32'h0;
      repeat (3) @(negedge CLK);
      chk_reset_vals("reset");
      RST_n = 1'b1;

      sweep("zeros", 0, 0, -1);

      for (int k = 0; k < 64; k++) bank[k] = 32'h1 << (k % 32);
      sweep("walk1", 0, 0, -1);

      for (int k = 0; k < 64; k++) bank[k] = 32'h0;
      bank[37] = 32'h0000_0100;
      sweep("word37", 0, 0, -1);

      fill_random();
      sweep("stall20", 20, 0, -1);

      fill_random();
      sweep("restart", 0, 0, 10);

      fill_random();
      sweep("rnd_ready", 0, 1, -1);

      fill_random();
      @(negedge CLK);
      start = 1'b1;
      m_ready = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge CLK);
         start = 1'b0;
         m_ready = 1'($urandom_range(0, 1));
         if (c == 30) RST_n = 1'b0;
      end
      @(negedge CLK);
      RST_n = 1'b1;
      chk_reset_vals("midrst");
      @(negedge CLK);
      chk("midrst_idle_done", done, 0);
      chk("midrst_idle_valid", m_valid, 0);

      fill_random();
      sweep("after_rst", 0, 1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/prm_result_scan.md
Name: prm_result_scan

Overview:
- Downstream consumer of the edge-result bank readout mux.
- On a start pulse, sweeps sel1/sel2 over all 64 32-bit words of the 2048-bit edge result.
- Buffers the words in a small FIFO and streams them out over a valid/ready interface.
- Accumulates a total set-bit count and the index of the lowest set bit for the sweep.

Parameters:
- NUM_BANKS, 4, number of 512-bit banks addressed by sel1.
- WORDS_PER_BANK, 16, number of 32-bit words per bank addressed by sel2.
- WORD_W, 32, width of result_imp and m_data.
- FIFO_DEPTH, 4, output buffer depth; power of two, minimum 2.

Ports:
- CLK  in  1  clock.
- RST_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
- sel1  out  3  bank select to the readout mux; registered.
- sel2  out  8  word select to the readout mux; registered; bits [7:4] are always 0.
- result_imp  in  32  word returned combinationally for the current sel1/sel2.
- m_data  out  32  streamed word.
- m_index  out  6  word index of m_data: sel1*16 + sel2.
- m_last  out  1  high with word index 63.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- busy  out  1  high from the cycle after start is accepted until the cycle after done.
- done  out  1  one-cycle pulse when the sweep is complete and the FIFO is empty.
- hit_count  out  12  popcount of all 2048 bits; saturates at 2047 (not reachable in practice).
- first_hit  out  11  bit index of the lowest set bit: word_index*32 + bit.
- first_hit_valid  out  1  first_hit holds a valid index.

Behaviour:
- Reset values: sel1=0, sel2=0, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, done=0, hit_count=0, first_hit=0, first_hit_valid=0. FIFO empty, state IDLE, addr=0.
- Addressing: addr is 6 bits; sel1={1'b0,addr[5:4]}, sel2={4'b0,addr[3:0]}.
- IDLE:
  - start=1 -> clear addr, hit_count, first_hit and first_hit_valid; go to SCAN.
  - busy=1 from the next cycle.
- SCAN, each cycle:
  - If the FIFO is not full: push {addr, result_imp}. The word is sampled at the clock edge closing a cycle in which sel1/sel2 already held addr, so one-cycle address setup is inherent.
  - In the same cycle: hit_count += popcount(result_imp).
  - If first_hit_valid=0 and result_imp!=0: first_hit={addr, index of lowest set bit}, first_hit_valid=1.
  - Then addr++.
  - If the FIFO is full: no push, no accumulation, addr holds.
  - A push at addr=63 moves the FSM to DRAIN.
- DRAIN: once the FIFO is empty, done=1 for one cycle and the FSM returns to IDLE. busy drops in the cycle after done.
- Stream rules:
  - Standard valid/ready: a transfer occurs when m_valid&&m_ready.
  - m_data, m_index and m_last are stable while m_valid=1 and m_ready=0.
  - Push and pop may happen in the same cycle when the FIFO is full: a pop frees a slot, but a push is allowed only if the full flag is low at the start of the cycle (no bypass).
  - Output is the FIFO head register; the first word appears on m_valid 1 cycle after its push.
- Minimum sweep time with m_ready held high: 64 SCAN cycles + 1 cycle pipeline + 1 DRAIN cycle; done asserts 66 cycles after the start cycle.
- hit_count and first_hit are valid once done is seen. Both hold until the next accepted start.
- start during busy is ignored and has no effect on the running sweep.
- Reset mid-sweep:
  - All state clears and the FIFO is flushed.
  - No done pulse is issued.
  - A partially streamed sweep is abandoned; the sink must discard a packet that has no m_last.
- Coherence: the upstream bank updates once every 32 cycles. Freezing the upstream during a sweep is a system-level requirement. This block samples whatever result_imp presents.

Decomposition:
- Shared package prm_pkg holds NUM_BANKS, WORDS_PER_BANK, WORD_W, TOTAL_WORDS=64, and the state enum {IDLE, SCAN, DRAIN}.
- One sub-module, prm_scan_fifo: a synchronous FIFO with WIDTH=WORD_W+6+1, DEPTH=FIFO_DEPTH, and full/empty flags, with a registered head.
- Popcount and lowest-set-bit logic stay inline as functions.

Test Plan:
- All-zero bank, m_ready=1, start -> 64 beats, m_index 0..63, m_last only on beat 63, done 66 cycles after start, hit_count=0, first_hit_valid=0.
- Model word k = 32'h1 << (k%32), m_ready=1 -> hit_count=64, first_hit=0, first_hit_valid=1; all m_data match the model.
- Only word 37 = 32'h0000_0100, rest 0 -> first_hit=37*32+8=1192, hit_count=1.
- m_ready held 0 for 20 cycles after start -> exactly FIFO_DEPTH pushes then addr stalls; beats are stable with no loss or duplication on release; all 64 beats delivered in order.
- start pulsed again at cycle 10 of a sweep -> ignored; single done; hit_count equals the single-sweep value.
- RST_n low for 1 cycle at sweep cycle 30 -> next cycle all outputs at reset values, m_valid=0, no done; a subsequent start completes normally.
